// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 funct3 codes, FSM states and
// the request legality check used at accept time.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // Illegal funct3 for the direction, or an address not aligned to the access size.
    function automatic logic req_error(input logic [1:0] byte_off,
                                       input logic       wen,
                                       input logic [2:0] funct3);
        logic err;
        err = 1'b0;
        case (funct3)
            LB:      err = 1'b0;
            LH:      err = byte_off[0];
            LW:      err = (byte_off != 2'b00);
            LBU:     err = wen;
            LHU:     err = wen | byte_off[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: moves the addressed byte/halfword of the RAM word down to
// bit 0 and sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      byte_off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {byte_off, 3'b000};
        case (funct3)
            LB:      data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            LH:      data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            LW:      data = shifted;
            LBU:     data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            LHU:     data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit between EXU and the RAM data port: one request at a time,
// alignment checking, byte-lane stores and extended load results.
module lsu_dmem_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic            in_wen,
    input  logic [2:0]      in_funct3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rdata,
    output logic            out_err,
    output logic            dmem_valid,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic            dmem_wen,
    output logic [3:0]      dmem_wmask,
    input  logic [XLEN-1:0] dmem_rdata
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    state_t          state, state_nxt;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            req_wen;
    logic [2:0]      req_funct3;
    logic [CNT_W-1:0] cnt;
    logic            first;
    logic            in_err;
    logic [XLEN-1:0] load_data;
    logic [3:0]      store_mask;
    logic [XLEN-1:0] store_data;

    assign in_err = req_error(in_addr[1:0], in_wen, in_funct3);

    lsu_load_align #(.XLEN(XLEN)) u_load_align (
        .rdata    (dmem_rdata),
        .byte_off (req_addr[1:0]),
        .funct3   (req_funct3),
        .data     (load_data)
    );

    // Loads leave mask and data at zero so a load can never disturb the RAM.
    always_comb begin
        store_mask = '0;
        store_data = '0;
        if (req_wen) begin
            case (req_funct3)
                SB: begin
                    store_mask = 4'b0001 << req_addr[1:0];
                    store_data = {4{req_wdata[7:0]}};
                end
                SH: begin
                    store_mask = 4'b0011 << req_addr[1:0];
                    store_data = {2{req_wdata[15:0]}};
                end
                SW: begin
                    store_mask = 4'b1111;
                    store_data = req_wdata;
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        dmem_valid = 1'b0;
        dmem_wen   = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_wmask = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = in_err ? RESP : ACCESS;
            end
            ACCESS: begin
                dmem_valid = 1'b1;
                // The RAM writes for as long as wen is high, so only the first cycle may write.
                dmem_wen   = req_wen & first;
                dmem_addr  = {req_addr[XLEN-1:2], 2'b00};
                dmem_wdata = store_data;
                dmem_wmask = store_mask;
                if (cnt == '0) state_nxt = RESP;
            end
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_wen    <= 1'b0;
            req_funct3 <= '0;
            cnt        <= '0;
            first      <= 1'b0;
            out_rdata  <= '0;
            out_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        req_addr   <= in_addr;
                        req_wdata  <= in_wdata;
                        req_wen    <= in_wen;
                        req_funct3 <= in_funct3;
                        cnt        <= CNT_W'(MEM_LATENCY - 1);
                        first      <= 1'b1;
                        out_err    <= in_err;
                        out_rdata  <= '0;
                    end
                end
                ACCESS: begin
                    first <= 1'b0;
                    if (cnt == '0) out_rdata <= req_wen ? '0 : load_data;
                    else           cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
